// File: rtl/lfsr_gen.sv
// Run-time configurable LFSR pattern generator: Fibonacci or Galois update,
// start/stop handshake, programmable step count and zero-seed lockup flag.
module lfsr_gen #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [WIDTH-1:0] taps_i,
    input  logic             mode_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic [WIDTH-1:0] lfsr_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             lockup_o
);

    generate
        if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
            $error("lfsr_gen: WIDTH must be within 4..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] taps_q;
    logic             mode_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             lockup_q;

    logic [WIDTH-1:0] fib_next_c;
    logic [WIDTH-1:0] gal_next_c;
    logic [WIDTH-1:0] next_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             last_c;

    // Next LFSR state from the captured configuration only.
    always_comb begin
        fib_next_c = {^(lfsr_q & taps_q), lfsr_q[WIDTH-1:1]};
        gal_next_c = (lfsr_q >> 1) ^ (lfsr_q[0] ? taps_q : '0);
        next_c     = mode_q ? gal_next_c : fib_next_c;
    end

    // cnt_q < len_q while running, so the increment never wraps.
    always_comb begin
        cnt_inc_c = cnt_q + CNT_W'(1);
        last_c    = (cnt_inc_c == len_q);
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q  <= S_IDLE;
            lfsr_q   <= '0;
            taps_q   <= '0;
            mode_q   <= 1'b0;
            len_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    // Start wins over a simultaneous stop; stop alone is ignored here.
                    if (start_i) begin
                        lfsr_q   <= seed_i;
                        taps_q   <= taps_i;
                        mode_q   <= mode_i;
                        len_q    <= len_i;
                        cnt_q    <= '0;
                        done_q   <= 1'b0;
                        lockup_q <= 1'b0;
                        if (seed_i == '0) begin
                            lockup_q <= 1'b1;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= S_DONE;
                        end else if (len_i == '0) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (stop_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        lfsr_q  <= next_c;
                        cnt_q   <= cnt_inc_c;
                        valid_q <= 1'b1;
                        if (last_c) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign lfsr_o   = lfsr_q;
    assign valid_o  = valid_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign lockup_o = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: vector table of complete runs plus
// hand-written sequences for period, abort, ignored start, reset and back-to-back.
module tb_lfsr_gen;

    logic        clk_i;
    logic        nreset_i;
    logic [15:0] seed_i;
    logic [15:0] taps_i;
    logic        mode_i;
    logic [15:0] len_i;
    logic        start_i;
    logic        stop_i;
    logic [15:0] lfsr_o;
    logic        valid_o;
    logic        busy_o;
    logic        done_o;
    logic        lockup_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    lfsr_gen #(.WIDTH(16), .CNT_W(16)) dut (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .seed_i   (seed_i),
        .taps_i   (taps_i),
        .mode_i   (mode_i),
        .len_i    (len_i),
        .start_i  (start_i),
        .stop_i   (stop_i),
        .lfsr_o   (lfsr_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .lockup_o (lockup_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] seed;
        logic [15:0] taps;
        logic        mode;
        logic [15:0] len;
        logic [15:0] exp_lfsr;
        logic        exp_lockup;
        int          exp_steps;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic launch(input logic [15:0] seed, input logic [15:0] taps,
                          input logic mode, input logic [15:0] len);
        seed_i  = seed;
        taps_i  = taps;
        mode_i  = mode;
        len_i   = len;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        // Scramble ports: a running job must only use captured values.
        seed_i  = ~seed;
        taps_i  = ~taps;
        mode_i  = ~mode;
        len_i   = 16'd0;
    endtask

    // One full run from launch to done; called at a negedge.
    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int vcnt;
        launch(v.seed, v.taps, v.mode, v.len);
        check({tag, "_busy0"}, 32'(busy_o), 32'(v.exp_steps != 0));
        check({tag, "_valid0"}, 32'(valid_o), 32'd0);
        n = 0;
        vcnt = 0;
        while (!done_o && n < v.exp_steps + 5) begin
            @(negedge clk_i);
            n++;
            if (valid_o) vcnt++;
        end
        check({tag, "_latency"}, 32'(n), 32'(v.exp_steps));
        check({tag, "_valids"}, 32'(vcnt), 32'(v.exp_steps));
        check({tag, "_lfsr"}, 32'(lfsr_o), 32'(v.exp_lfsr));
        check({tag, "_lockup"}, 32'(lockup_o), 32'(v.exp_lockup));
        check({tag, "_busy_end"}, 32'(busy_o), 32'd0);
    endtask

    vec_t vecs [10];
    bit   seen [65536];

    initial begin
        int n;
        int vcnt;
        int reps;
        vec_t v;

        vecs[0] = '{16'hACE1, 16'h002D, 1'b0, 16'd1,  16'h5670, 1'b0, 1};
        vecs[1] = '{16'hACE1, 16'h002D, 1'b0, 16'd2,  16'hAB38, 1'b0, 2};
        vecs[2] = '{16'hACE1, 16'h002D, 1'b0, 16'd3,  16'h559C, 1'b0, 3};
        vecs[3] = '{16'hACE1, 16'hB400, 1'b1, 16'd1,  16'hE270, 1'b0, 1};
        vecs[4] = '{16'hACE1, 16'hB400, 1'b1, 16'd3,  16'h389C, 1'b0, 3};
        vecs[5] = '{16'h0000, 16'h002D, 1'b0, 16'd10, 16'h0000, 1'b1, 0};
        vecs[6] = '{16'h1234, 16'h002D, 1'b0, 16'd0,  16'h1234, 1'b0, 0};
        vecs[7] = '{16'h8000, 16'h0000, 1'b0, 16'd3,  16'h1000, 1'b0, 3};
        vecs[8] = '{16'h0003, 16'h0000, 1'b1, 16'd2,  16'h0000, 1'b0, 2};
        vecs[9] = '{16'h0001, 16'hFFFF, 1'b1, 16'd1,  16'hFFFF, 1'b0, 1};

        nreset_i = 1'b0;
        seed_i = '0; taps_i = '0; mode_i = 1'b0; len_i = '0;
        start_i = 1'b0; stop_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_outputs", {12'd0, lfsr_o, valid_o, busy_o, done_o, lockup_o}, 32'd0);
        nreset_i = 1'b1;
        @(negedge clk_i);

        foreach (vecs[i]) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
            @(negedge clk_i);
            check($sformatf("v%0d_valid_drop", i), 32'(valid_o), 32'd0);
            check($sformatf("v%0d_done_hold", i), 32'(done_o), 32'd1);
        end

        // Full Fibonacci period with the maximum step count.
        launch(16'hACE1, 16'h002D, 1'b0, 16'hFFFF);
        foreach (seen[i]) seen[i] = 1'b0;
        seen[16'hACE1] = 1'b1;
        n = 0; vcnt = 0; reps = 0;
        while (!done_o && n < 70000) begin
            @(negedge clk_i);
            n++;
            if (valid_o) begin
                vcnt++;
                if (n < 65535) begin
                    if (seen[lfsr_o]) reps++;
                    seen[lfsr_o] = 1'b1;
                end
            end
        end
        check("period_latency", 32'(n), 32'd65535);
        check("period_valids", 32'(vcnt), 32'd65535);
        check("period_repeats", 32'(reps), 32'd0);
        check("period_final", 32'(lfsr_o), 32'h0000ACE1);

        // Abort after three updates, with an ignored start while running.
        @(negedge clk_i);
        launch(16'hACE1, 16'h002D, 1'b0, 16'd100);
        @(negedge clk_i);
        seed_i = 16'h0000; len_i = 16'd1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check("abort_s2_lfsr", 32'(lfsr_o), 32'h0000AB38);
        check("abort_s2_flags", {29'd0, busy_o, done_o, lockup_o}, 32'b100);
        @(negedge clk_i);
        check("abort_s3_lfsr", 32'(lfsr_o), 32'h0000559C);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        check("abort_lfsr", 32'(lfsr_o), 32'h0000559C);
        check("abort_flags", {29'd0, busy_o, valid_o, done_o}, 32'b000);
        stop_i = 1'b1;
        repeat (2) @(negedge clk_i);
        stop_i = 1'b0;
        check("idle_stop_ignored", {12'd0, lfsr_o, valid_o, busy_o, done_o, lockup_o},
              {12'd0, 16'h559C, 4'b0000});

        // Start with stop also high wins; a mid-run start must not reset the counter.
        stop_i = 1'b1;
        launch(16'hACE1, 16'hB400, 1'b1, 16'd3);
        stop_i = 1'b0;
        check("startstop_busy", 32'(busy_o), 32'd1);
        seed_i = 16'h1111; len_i = 16'd1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        n = 1;
        while (!done_o && n < 10) begin
            @(negedge clk_i);
            n++;
        end
        check("ignstart_latency", 32'(n), 32'd3);
        check("ignstart_lfsr", 32'(lfsr_o), 32'h0000389C);

        // Back-to-back: start during the first DONE cycle.
        launch(16'hACE1, 16'hB400, 1'b1, 16'd1);
        check("b2b_busy", {29'd0, busy_o, done_o, valid_o}, 32'b100);
        check("b2b_seed", 32'(lfsr_o), 32'h0000ACE1);
        @(negedge clk_i);
        check("b2b_result", {12'd0, lfsr_o, valid_o, busy_o, done_o, lockup_o},
              {12'd0, 16'hE270, 4'b1010});

        // Asynchronous reset between edges mid-run.
        @(negedge clk_i);
        launch(16'hACE1, 16'h002D, 1'b0, 16'd50);
        repeat (4) @(negedge clk_i);
        #1 nreset_i = 1'b0;
        #1;
        check("async_rst", {12'd0, lfsr_o, valid_o, busy_o, done_o, lockup_o}, 32'd0);
        @(negedge clk_i);
        nreset_i = 1'b1;
        @(negedge clk_i);
        v = vecs[0];
        run_vec(v, "post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
